// File: rtl/serdes_pkg.sv
// -----------------------------------------------------------------------------
// serdes_pkg
// Shared constants, FSM state type and the header-byte builder used by the
// serializer transmit scheduler and its round-robin arbiter.
// No ports (package).
// -----------------------------------------------------------------------------
package serdes_pkg;

    localparam logic [3:0] HDR_MAGIC = 4'hA;
    localparam int         SLOT_LEN  = 8;
    localparam int         BYTE_W    = 8;
    localparam int         CNT_W     = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    // Header byte: magic nibble on top, requester ID (already zero-extended) below.
    function automatic logic [BYTE_W-1:0] make_header(input logic [3:0] id);
        return {HDR_MAGIC, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts one position
// after the previous winner (modulo N_REQ) and takes the first set request.
// Ports:
//   i_req        in  N_REQ  request vector
//   i_last_grant in  ID_W   index of the previous winner
//   o_grant      out N_REQ  one-hot grant (all zero when no request)
//   o_grant_idx  out ID_W   encoded grant index
//   o_any        out 1      at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_last_grant,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_grant_idx,
    output logic             o_any
);

    int              w_cand;
    logic [ID_W-1:0] w_cand_idx;
    logic            w_found;

    // Rotating priority search; the first hit after last_grant wins.
    always_comb begin
        o_grant     = {N_REQ{1'b0}};
        o_grant_idx = {ID_W{1'b0}};
        w_found     = 1'b0;
        w_cand      = 0;
        w_cand_idx  = {ID_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            // last_grant+1+i never reaches 2*N_REQ, so one wrap suffices.
            w_cand = int'(i_last_grant) + 1 + i;
            if (w_cand >= N_REQ) begin
                w_cand = w_cand - N_REQ;
            end else begin
                w_cand = w_cand;
            end
            w_cand_idx = w_cand[ID_W-1:0];
            if (!w_found && i_req[w_cand_idx]) begin
                w_found              = 1'b1;
                o_grant[w_cand_idx]  = 1'b1;
                o_grant_idx          = w_cand_idx;
            end else begin
                w_found = w_found;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/serdes_tx_sched.sv
// -----------------------------------------------------------------------------
// serdes_tx_sched
// Round-robin transmit scheduler feeding one 8-bit parallel-to-serial
// serializer. Each accepted byte is sent as a two-slot frame: a header byte
// {A, id} followed by the payload. Every slot is 8 clocks; a new byte is
// loaded (SOF strobe) at the first cycle of each slot.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   i_req_valid     N_REQ     per-requester byte pending
//   i_req_data      8*N_REQ   payloads, requester i on [8i+7:8i]
//   o_req_ready     N_REQ     one-hot accept (combinational)
//   o_ser_sof       1         serializer load strobe (registered)
//   o_ser_din       8         serializer parallel byte (registered)
//   o_ser_id        ID_W      ID of the frame on the line (registered)
//   o_busy          1         frame in flight (registered)
//   o_frame_cnt     16        frames sent, wrapping (registered)
// FRAME_CNT_RST is the reset value of the frame counter (0 in normal use).
// -----------------------------------------------------------------------------
module serdes_tx_sched
    import serdes_pkg::*;
#(
    parameter int          N_REQ         = 4,
    parameter int          ID_W          = 2,
    parameter logic [15:0] FRAME_CNT_RST = 16'h0000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [BYTE_W*N_REQ-1:0] i_req_data,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic                    o_ser_sof,
    output logic [BYTE_W-1:0]       o_ser_din,
    output logic [ID_W-1:0]         o_ser_id,
    output logic                    o_busy,
    output logic [15:0]             o_frame_cnt
);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [BYTE_W-1:0]   r_payload;
    logic [ID_W-1:0]     r_last_grant;
    logic                r_ser_sof;
    logic [BYTE_W-1:0]   r_ser_din;
    logic [ID_W-1:0]     r_ser_id;
    logic                r_busy;
    logic [15:0]         r_frame_cnt;

    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [BYTE_W-1:0]   w_payload_nxt;
    logic [ID_W-1:0]     w_last_grant_nxt;
    logic                w_ser_sof_nxt;
    logic [BYTE_W-1:0]   w_ser_din_nxt;
    logic [ID_W-1:0]     w_ser_id_nxt;
    logic                w_busy_nxt;
    logic [15:0]         w_frame_cnt_nxt;

    logic [N_REQ-1:0]    w_grant;
    logic [ID_W-1:0]     w_grant_idx;
    logic                w_any;
    logic                w_slot_end;
    logic                w_accept_pt;
    logic                w_accept;
    logic [BYTE_W-1:0]   w_sel_data;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req        (i_req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_any        (w_any)
    );

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_accept_pt = (r_state == IDLE) || ((r_state == DATA) && w_slot_end);
    // Reset blocks acceptance so no requester believes it was taken.
    assign w_accept    = w_accept_pt && w_any && !RST;
    assign w_sel_data  = i_req_data[{w_grant_idx, 3'b000} +: BYTE_W];

    // Accept strobe back to the requesters.
    always_comb begin
        if (w_accept) begin
            o_req_ready = w_grant;
        end else begin
            o_req_ready = {N_REQ{1'b0}};
        end
    end

    // Next-state and next-output logic for the slot FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt + 3'd1;
        w_payload_nxt    = r_payload;
        w_last_grant_nxt = r_last_grant;
        w_ser_sof_nxt    = 1'b0;
        w_ser_din_nxt    = r_ser_din;
        w_ser_id_nxt     = r_ser_id;
        w_busy_nxt       = r_busy;
        w_frame_cnt_nxt  = r_frame_cnt;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = 3'd0;
                if (w_accept) begin
                    w_state_nxt      = HDR;
                    w_payload_nxt    = w_sel_data;
                    w_last_grant_nxt = w_grant_idx;
                    w_ser_sof_nxt    = 1'b1;
                    w_ser_din_nxt    = make_header(4'(w_grant_idx));
                    w_ser_id_nxt     = w_grant_idx;
                    w_busy_nxt       = 1'b1;
                end else begin
                    w_busy_nxt = 1'b0;
                end
            end
            HDR: begin
                if (w_slot_end) begin
                    w_state_nxt   = DATA;
                    w_cnt_nxt     = 3'd0;
                    w_ser_sof_nxt = 1'b1;
                    w_ser_din_nxt = r_payload;
                end else begin
                    w_state_nxt = HDR;
                end
            end
            DATA: begin
                if (w_slot_end) begin
                    w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                    w_cnt_nxt       = 3'd0;
                    // Back-to-back: next header loads with no idle gap.
                    if (w_accept) begin
                        w_state_nxt      = HDR;
                        w_payload_nxt    = w_sel_data;
                        w_last_grant_nxt = w_grant_idx;
                        w_ser_sof_nxt    = 1'b1;
                        w_ser_din_nxt    = make_header(4'(w_grant_idx));
                        w_ser_id_nxt     = w_grant_idx;
                        w_busy_nxt       = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
                    w_state_nxt = DATA;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 3'd0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // FSM state and slot counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Payload, arbitration history and registered serializer outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_payload    <= 8'h00;
            r_last_grant <= ID_W'(N_REQ - 1);
            r_ser_sof    <= 1'b0;
            r_ser_din    <= 8'h00;
            r_ser_id     <= {ID_W{1'b0}};
            r_busy       <= 1'b0;
            r_frame_cnt  <= FRAME_CNT_RST;
        end else begin
            r_payload    <= w_payload_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_ser_sof    <= w_ser_sof_nxt;
            r_ser_din    <= w_ser_din_nxt;
            r_ser_id     <= w_ser_id_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
        end
    end

    assign o_ser_sof   = r_ser_sof;
    assign o_ser_din   = r_ser_din;
    assign o_ser_id    = r_ser_id;
    assign o_busy      = r_busy;
    assign o_frame_cnt = r_frame_cnt;

endmodule

// File: doc/serdes_tx_sched.md
# serdes_tx_sched

Round-robin transmit scheduler that shares one 8-bit parallel-to-serial serializer among `N_REQ` byte requesters. Each accepted byte goes out as a 2-byte frame, a header byte carrying the requester ID followed by the payload byte. The block drives the serializer's load strobe and parallel data so that a new byte is loaded exactly every 8 clocks while frames are queued. It sits between the requesters and the serializer's `SOF_IN`/`DIN` inputs.

## Interface
- `N_REQ`, default 4. Number of requesters; legal range 2..16.
- `ID_W`, default 2. Requester ID width; equals clog2(`N_REQ`); at most 4.
- `CLK`  in  1  clock.
- `RST`  in  1  reset, synchronous, active-high.
- `REQ_VALID`  in  `N_REQ`  per-requester byte pending.
- `REQ_DATA`  in  8*`N_REQ`  payload; requester i drives bits [8i+7:8i].
- `REQ_READY`  out  `N_REQ`  one-hot accept, combinational.
- `SER_SOF`  out  1  serializer load strobe, registered.
- `SER_DIN`  out  8  serializer parallel byte, registered.
- `SER_ID`  out  `ID_W`  ID of the frame currently on the line, registered.
- `BUSY`  out  1  high while a frame is in flight, registered.
- `FRAME_CNT`  out  16  count of frames sent, wraps at 16'hFFFF to 0.

## Operation
- States:
  - IDLE: no frame in flight.
  - HDR: header slot.
  - DATA: payload slot.
- Each slot lasts 8 cycles, tracked by a 3-bit slot counter `cnt` running 0..7.
- Accept points are IDLE, and DATA when `cnt`=7.
  - At an accept point, if any `REQ_VALID` is set, the round-robin arbiter picks requester g.
  - `REQ_READY[g]`=1 in that cycle; all other `REQ_READY` bits are 0.
  - The transfer completes on that clock edge.
  - On that edge the payload is captured, `last_grant`<=g, the FSM moves to HDR with `cnt`=0, `SER_SOF`<=1 and `SER_DIN`<=header.
- Header byte = {4'hA, g zero-extended to 4 bits}.
- Leaving HDR (`cnt`=7): FSM moves to DATA with `cnt`=0, `SER_SOF`<=1, `SER_DIN`<=captured payload.
- DATA at `cnt`=7 with no `REQ_VALID` set: FSM moves to IDLE, `BUSY`<=0.
- `SER_SOF` is high for exactly one cycle, the first cycle of each slot; it is 0 in every other cycle.
- `SER_DIN` holds its value for the whole slot.
- `FRAME_CNT` increments by 1 on the edge that leaves DATA at `cnt`=7.
- Round-robin priority:
  - Search starts at `last_grant`+1 modulo `N_REQ` and takes the first set `REQ_VALID`.
  - A lone requester is granted repeatedly.
- `REQ_READY` is 0 everywhere outside accept points.
- A requester keeps `REQ_VALID` and `REQ_DATA` stable until accepted. Dropping `REQ_VALID` before acceptance is legal; that requester is then simply not granted.
- Reset values:
  - State IDLE, `cnt`=0.
  - `SER_SOF`=0, `SER_DIN`=8'h00, `SER_ID`=0, `BUSY`=0, `FRAME_CNT`=0.
  - `last_grant`=`N_REQ`-1, so requester 0 has first priority.
- `RST` dominates every other event, including reset mid-frame. The frame is aborted and `REQ_READY` is 0 during reset. The serializer's own reset is owned by the top level.

## Timing
- Latency from an accepting edge (IDLE) to the header `SER_SOF`: 1 cycle, because the output is registered.
- Payload `SER_SOF` follows the header `SER_SOF` by exactly 8 cycles.
- Back-to-back frames:
  - `SER_SOF` pulses every 8 cycles with no gap.
  - Frame period is 16 cycles.
  - Sustained throughput is 1 payload byte per 16 cycles.
- `BUSY` rises with the header `SER_SOF` and falls in the cycle after the last DATA slot ends, when no request is pending.
- `SER_ID` updates together with the header `SER_SOF` and is held through the DATA slot.
- No combinational path from `REQ_VALID` to `SER_*`. `REQ_READY` depends combinationally on `REQ_VALID`, state, `cnt` and `last_grant`.

## Structure
- Shared package `serdes_pkg` holds:
  - `HDR_MAGIC`=4'hA.
  - `SLOT_LEN`=8.
  - `BYTE_W`=8.
  - FSM state enum (IDLE, HDR, DATA).
- One natural sub-module, `rr_arbiter`: parameterised by `N_REQ`, purely combinational. Inputs are the request vector and `last_grant`; outputs are a one-hot grant and the encoded grant index.
- FSM, slot counter, payload register and outputs live in `serdes_tx_sched`.

## Test plan
- Reset then single request: `REQ_VALID`=4'b0010, `REQ_DATA[15:8]`=8'h5C, from IDLE.
  - `REQ_READY`=4'b0010 for 1 cycle.
  - Next cycle `SER_SOF`=1, `SER_DIN`=8'hA1.
  - 8 cycles later `SER_SOF`=1, `SER_DIN`=8'h5C.
  - `FRAME_CNT`=1 after 16 cycles.
- All four requesters valid continuously:
  - Grants in order 0,1,2,3,0.
  - Headers A0,A1,A2,A3,A0.
  - `SER_SOF` period exactly 8 cycles; `BUSY` never drops.
- Requester 2 alone, valid continuously:
  - Grant to 2 every 16 cycles; headers all 8'hA2.
- Request arrives during HDR `cnt`=3:
  - No `REQ_READY` until DATA `cnt`=7.
  - Its header `SER_SOF` follows the previous payload slot with no gap.
- `RST` asserted at DATA `cnt`=4:
  - Next cycle all outputs are at reset values.
  - After `RST` drops, a pending request from requester 3 with requester 0 also valid: requester 0 is granted first.
- `FRAME_CNT` preset near wrap via 65535 frames, or forced in simulation:
  - 16'hFFFF rolls to 16'h0000 on the next frame end.
